axi4_lite_arbiter2: RTL

Two-requester arbiter in front of axi4_lite_manager. It shares the single AXI4-Lite manager port between CORE0's data bus (requester 0) and the debug unit (requester 1). Each requester uses the manager's native rd_en/wr_en/addr/wr_data/wr_strobe → rd_data/access_fault/busy protocol. One transaction is in flight at a time; grants are round-robin or fixed-priority, with an issue timeout.

---
 rtl/axi4_lite_arbiter2.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axi4_lite_arbiter2.sv
// Two-requester front end for the AXI4-Lite manager: one transaction in flight,
// round-robin or fixed-priority grant, with a timeout if the manager never goes busy.
module axi4_lite_arbiter2 #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int ISSUE_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_rd_en,
  input  logic                  r0_wr_en,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]      r0_wr_data,
  input  logic [WIDTH/8-1:0]    r0_wr_strobe,
  output logic [WIDTH-1:0]      r0_rd_data,
  output logic                  r0_access_fault,
  output logic                  r0_busy,
  input  logic                  r1_rd_en,
  input  logic                  r1_wr_en,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wr_data,
  input  logic [WIDTH/8-1:0]    r1_wr_strobe,
  output logic [WIDTH-1:0]      r1_rd_data,
  output logic                  r1_access_fault,
  output logic                  r1_busy,
  output logic                  m_rd_en,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wr_data,
  output logic [WIDTH/8-1:0]    m_wr_strobe,
  input  logic [WIDTH-1:0]      m_rd_data,
  input  logic                  m_access_fault,
  input  logic                  m_busy
);

  localparam int SW = WIDTH / 8;
  localparam int CW = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ISSUE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_grant;
  logic                  r_is_wr;
  logic                  r_m_rd_en;
  logic                  r_m_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wr_data;
  logic [SW-1:0]         r_wr_strobe;
  logic [WIDTH-1:0]      r_rsp_data;
  logic                  r_rsp_fault;
  logic [CW-1:0]         r_cnt;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_pick1;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_data;
  logic [SW-1:0]         w_sel_strobe;
  logic                  w_resp0;
  logic                  w_resp1;

  assign w_req0 = r0_rd_en | r0_wr_en;
  assign w_req1 = r1_rd_en | r1_wr_en;

  // On a tie, round-robin hands the bus to whoever did not have it last.
  assign w_pick1      = w_req1 & (~w_req0 | (~FIXED_PRIORITY & ~r_last_grant));
  assign w_sel_wr     = w_pick1 ? r1_wr_en     : r0_wr_en;
  assign w_sel_addr   = w_pick1 ? r1_addr      : r0_addr;
  assign w_sel_data   = w_pick1 ? r1_wr_data   : r0_wr_data;
  assign w_sel_strobe = w_pick1 ? r1_wr_strobe : r0_wr_strobe;

  assign w_resp0 = (r_state == S_RESP) & ~r_grant;
  assign w_resp1 = (r_state == S_RESP) &  r_grant;

  assign r0_busy         = w_req0 & ~w_resp0;
  assign r1_busy         = w_req1 & ~w_resp1;
  assign r0_rd_data      = w_resp0 ? r_rsp_data : '0;
  assign r1_rd_data      = w_resp1 ? r_rsp_data : '0;
  assign r0_access_fault = w_resp0 & r_rsp_fault;
  assign r1_access_fault = w_resp1 & r_rsp_fault;

  assign m_rd_en     = r_m_rd_en;
  assign m_wr_en     = r_m_wr_en;
  assign m_addr      = r_addr;
  assign m_wr_data   = r_wr_data;
  assign m_wr_strobe = r_wr_strobe;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the async reset clears all of it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_is_wr      <= 1'b0;
      r_m_rd_en    <= 1'b0;
      r_m_wr_en    <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_wr_strobe  <= '0;
      r_rsp_data   <= '0;
      r_rsp_fault  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant     <= w_pick1;
            r_is_wr     <= w_sel_wr;
            r_m_wr_en   <= w_sel_wr;
            r_m_rd_en   <= ~w_sel_wr;
            r_addr      <= w_sel_addr;
            r_wr_data   <= w_sel_data;
            r_wr_strobe <= w_sel_strobe;
            r_cnt       <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_busy) begin
            r_m_rd_en <= 1'b0;
            r_m_wr_en <= 1'b0;
            r_state   <= S_WAIT;
          end else if (r_cnt == TO_LAST) begin
            r_m_rd_en   <= 1'b0;
            r_m_wr_en   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_fault <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!m_busy) begin
            r_rsp_data  <= r_is_wr ? '0 : m_rd_data;
            r_rsp_fault <= m_access_fault;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
